// File: rtl/mode_stepper_pkg.sv
// Shared front-panel stepper types and default timing for the 100 MHz board clock.
package mode_stepper_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESSED,
      S_REPEAT
   } repeat_state_t;

   localparam int unsigned CLK_HZ                = 100_000_000;
   localparam int unsigned HOLD_CYCLES_DEFAULT   = CLK_HZ / 4;   // 250 ms to first repeat
   localparam int unsigned REPEAT_CYCLES_DEFAULT = CLK_HZ / 20;  // 50 ms between repeats

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mode_stepper_if.sv
// Front-panel control and mode result bundle for one mode_stepper instance.
interface mode_stepper_if #(
   parameter int unsigned MODE_W = 2
);
   logic              ena;
   logic              btn_up;
   logic              btn_down;
   logic              load_en;
   logic [MODE_W-1:0] load_value;
   logic [MODE_W-1:0] mode_out;
   logic              changed;

   modport master (
      output ena, btn_up, btn_down, load_en, load_value,
      input  mode_out, changed
   );

   modport slave (
      input  ena, btn_up, btn_down, load_en, load_value,
      output mode_out, changed
   );
endinterface

// File: rtl/mode_stepper_button_repeater.sv
// Turns a debounced button level into step pulses: one on press, then hold-to-repeat.
//
// state     | meaning
// S_IDLE    | button released (or held since reset), waiting for a fresh press edge
// S_PRESSED | first step issued, down-counting the hold delay
// S_REPEAT  | hold delay expired, stepping every REPEAT_CYCLES while held
module button_repeater
   import mode_stepper_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
   parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic step
);

   localparam int unsigned     CNT_W     = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

   repeat_state_t    state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             step_nxt;
   logic             btn_q;
   logic             armed;   // a low level has been seen since reset

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         step  <= 1'b0;
         btn_q <= 1'b0;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         step  <= step_nxt;
         btn_q <= btn;
         armed <= armed | ~btn;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step_nxt  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (btn && !btn_q && armed) begin
               step_nxt  = 1'b1;
               cnt_nxt   = HOLD_LOAD;
               state_nxt = S_PRESSED;
            end
         end
         S_PRESSED: begin
            // Without repeat the counter is frozen: one step per press.
            if (!btn) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else if (REPEAT_EN) begin
               if (cnt == '0) begin
                  step_nxt  = 1'b1;
                  cnt_nxt   = REP_LOAD;
                  state_nxt = S_REPEAT;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
         end
         S_REPEAT: begin
            if (!btn) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else if (cnt == '0) begin
               step_nxt = 1'b1;
               cnt_nxt  = REP_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/mode_stepper.sv
// Mode index stepped by up/down buttons with auto-repeat, wrap/saturate ends and preset load.
module mode_stepper
   import mode_stepper_pkg::*;
#(
   parameter int unsigned NUM_MODES     = 4,
   parameter int unsigned RESET_MODE    = 0,
   parameter bit          WRAP          = 1'b1,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
   parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   mode_stepper_if.slave  bus
);

   localparam int unsigned      MODE_W   = $clog2(NUM_MODES);
   localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_MODES - 1);
   localparam logic [MODE_W-1:0] RST_MODE = MODE_W'(RESET_MODE);

   logic              step_up;
   logic              step_down;
   logic [MODE_W-1:0] mode_q, mode_nxt;
   logic              changed_q;

   button_repeater #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (REPEAT_EN)
   ) u_rep_up (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_up),
      .step  (step_up)
   );

   button_repeater #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (REPEAT_EN)
   ) u_rep_down (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_down),
      .step  (step_down)
   );

   // Load beats steps; coincident up/down cancel; disabled cycles drop steps.
   always_comb begin
      mode_nxt = mode_q;
      if (bus.ena) begin
         if (bus.load_en) begin
            mode_nxt = (32'(bus.load_value) >= NUM_MODES) ? MAX_MODE : bus.load_value;
         end else if (step_up && step_down) begin
            mode_nxt = mode_q;
         end else if (step_up) begin
            if (mode_q == MAX_MODE) mode_nxt = WRAP ? '0 : mode_q;
            else                    mode_nxt = mode_q + MODE_W'(1);
         end else if (step_down) begin
            if (mode_q == '0) mode_nxt = WRAP ? MAX_MODE : mode_q;
            else              mode_nxt = mode_q - MODE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= RST_MODE;
         changed_q <= 1'b0;
      end else begin
         mode_q    <= mode_nxt;
         changed_q <= (mode_nxt != mode_q);
      end
   end

   assign bus.mode_out = mode_q;
   assign bus.changed  = changed_q;

endmodule

// File: tb/tb_mode_stepper.sv
// Three stepper variants (wrap+repeat, saturate+repeat, wrap+single-step) driven in parallel.
module tb_mode_stepper;

   localparam int N = 5;
   localparam int H = 8;
   localparam int R = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       load_en = 1'b0;
   logic [2:0] load_value = 3'd0;

   int n_tests = 0;
   int n_fail  = 0;
   int chg_cnt_a = 0;

   always #5 clk = ~clk;

   mode_stepper_if #(.MODE_W(3)) if_a ();
   mode_stepper_if #(.MODE_W(3)) if_b ();
   mode_stepper_if #(.MODE_W(3)) if_c ();

   assign if_a.ena = ena;  assign if_a.btn_up = btn_up;  assign if_a.btn_down = btn_down;
   assign if_a.load_en = load_en;  assign if_a.load_value = load_value;
   assign if_b.ena = ena;  assign if_b.btn_up = btn_up;  assign if_b.btn_down = btn_down;
   assign if_b.load_en = load_en;  assign if_b.load_value = load_value;
   assign if_c.ena = ena;  assign if_c.btn_up = btn_up;  assign if_c.btn_down = btn_down;
   assign if_c.load_en = load_en;  assign if_c.load_value = load_value;

   mode_stepper #(.NUM_MODES(N), .RESET_MODE(0), .WRAP(1'b1), .REPEAT_EN(1'b1),
                  .HOLD_CYCLES(H), .REPEAT_CYCLES(R))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   mode_stepper #(.NUM_MODES(N), .RESET_MODE(0), .WRAP(1'b0), .REPEAT_EN(1'b1),
                  .HOLD_CYCLES(H), .REPEAT_CYCLES(R))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   mode_stepper #(.NUM_MODES(N), .RESET_MODE(0), .WRAP(1'b1), .REPEAT_EN(1'b0),
                  .HOLD_CYCLES(H), .REPEAT_CYCLES(R))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a button's held run length d (0 = first sampled-high cycle)
   // decides its steps; the step is applied to the mode one edge later.
   int d_up = -1, d_dn = -1;
   bit low_up = 1'b0, low_dn = 1'b0;
   bit pu[3], pd[3];
   int mm[3];
   bit mc[3];

   function automatic bit wrap_of(input int i); return i != 1; endfunction
   function automatic bit rep_of(input int i);  return i != 2; endfunction

   function automatic bit step_at(input int d, input bit rep);
      if (d < 0)  return 1'b0;
      if (d == 0) return 1'b1;
      if (!rep || d < H) return 1'b0;
      return ((d - H) % R) == 0;
   endfunction

   function automatic int run_len(input int d, input bit b, input bit low);
      if (!b)     return -1;
      if (d >= 0) return d + 1;
      return low ? 0 : -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_up = -1; d_dn = -1; low_up = 1'b0; low_dn = 1'b0;
         for (int i = 0; i < 3; i++) begin
            pu[i] = 1'b0; pd[i] = 1'b0; mm[i] = 0; mc[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            int old;
            old = mm[i];
            if (ena) begin
               if (load_en)
                  mm[i] = (int'(load_value) > N - 1) ? N - 1 : int'(load_value);
               else if (pu[i] && !pd[i])
                  mm[i] = wrap_of(i) ? (mm[i] + 1) % N : ((mm[i] + 1 > N - 1) ? N - 1 : mm[i] + 1);
               else if (pd[i] && !pu[i])
                  mm[i] = wrap_of(i) ? (mm[i] + N - 1) % N : ((mm[i] == 0) ? 0 : mm[i] - 1);
            end
            mc[i] = (mm[i] != old);
         end
         d_up = run_len(d_up, btn_up, low_up);
         d_dn = run_len(d_dn, btn_down, low_dn);
         if (!btn_up)   low_up = 1'b1;
         if (!btn_down) low_dn = 1'b1;
         for (int i = 0; i < 3; i++) begin
            pu[i] = step_at(d_up, rep_of(i));
            pd[i] = step_at(d_dn, rep_of(i));
         end
      end
   end

   always @(negedge clk) begin
      chk("a.mode",    int'(if_a.mode_out), mm[0]);
      chk("a.changed", int'(if_a.changed),  int'(mc[0]));
      chk("b.mode",    int'(if_b.mode_out), mm[1]);
      chk("b.changed", int'(if_b.changed),  int'(mc[1]));
      chk("c.mode",    int'(if_c.mode_out), mm[2]);
      chk("c.changed", int'(if_c.changed),  int'(mc[2]));
      if (if_a.changed) chg_cnt_a++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_up();
      btn_up = 1'b1; cyc(1); btn_up = 1'b0; cyc(2);
   endtask

   task automatic press_down();
      btn_down = 1'b1; cyc(1); btn_down = 1'b0; cyc(2);
   endtask

   task automatic load(input int v);
      load_en = 1'b1; load_value = 3'(v); cyc(1); load_en = 1'b0; cyc(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(2);
      chk("rst.mode_a", int'(if_a.mode_out), 0);
      chk("rst.changed_a", int'(if_a.changed), 0);
      rst_n = 1'b1;
      ena   = 1'b1;
      cyc(1);

      for (int i = 0; i < 5; i++) begin
         press_up();
         chk("press.a", int'(if_a.mode_out), (i + 1) % 5);
         chk("press.b", int'(if_b.mode_out), (i + 1 > 4) ? 4 : i + 1);
      end
      chk("press.chg_cnt", chg_cnt_a, 5);

      load(0);
      press_down();
      chk("sat_lo.b", int'(if_b.mode_out), 0);
      chk("wrap_lo.a", int'(if_a.mode_out), 4);
      load(4);
      press_up();
      chk("sat_hi.b", int'(if_b.mode_out), 4);
      chk("wrap_hi.a", int'(if_a.mode_out), 0);

      load(0);
      btn_up = 1'b1; cyc(20); btn_up = 1'b0; cyc(3);
      chk("hold20.a", int'(if_a.mode_out), 4);
      chk("hold20.b", int'(if_b.mode_out), 4);
      chk("hold20.c_norep", int'(if_c.mode_out), 1);

      load(7);
      chk("load_clamp.a", int'(if_a.mode_out), 4);
      btn_up = 1'b1; cyc(1);
      btn_up = 1'b0; load_en = 1'b1; load_value = 3'd2; cyc(1);
      load_en = 1'b0; cyc(2);
      chk("load_vs_step.a", int'(if_a.mode_out), 2);
      btn_up = 1'b1; btn_down = 1'b1; cyc(1);
      btn_up = 1'b0; btn_down = 1'b0; cyc(2);
      chk("up_down_cancel.a", int'(if_a.mode_out), 2);

      ena = 1'b0; btn_up = 1'b1; cyc(3);
      ena = 1'b1; cyc(4);
      btn_up = 1'b0; cyc(2);
      chk("ena_drop.a", int'(if_a.mode_out), 2);

      load(0);
      btn_up = 1'b1; cyc(14);
      chk("pre_rst.a", int'(if_a.mode_out), 3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst.a", int'(if_a.mode_out), 0);
      chk("async_rst.b", int'(if_b.mode_out), 0);
      chk("async_rst.chg_a", int'(if_a.changed), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(20);
      chk("held_thru_rst.a", int'(if_a.mode_out), 0);
      btn_up = 1'b0; cyc(1);
      press_up();
      chk("repress.a", int'(if_a.mode_out), 1);

      for (int s = 0; s < 60; s++) begin
         int len;
         len      = $urandom_range(1, 24);
         btn_up   = ($urandom % 2) == 0;
         btn_down = ($urandom % 3) == 0;
         for (int k = 0; k < len; k++) begin
            ena        = ($urandom % 8) != 0;
            load_en    = ($urandom % 16) == 0;
            load_value = 3'($urandom % 8);
            cyc(1);
         end
      end
      ena = 1'b1; load_en = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      cyc(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
